// File: rtl/msx_ram_arbiter.sv
// msx_ram_arbiter: shares one single-port synchronous RAM between the Z80 bus
// and the ioctl loader. The CPU wins whenever both are pending in IDLE. Loader
// bytes wait in a small FIFO and drain in idle cycles. Z80 WAIT_n is held low
// until the current bus cycle has had its single RAM access.
module msx_ram_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int LD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_addr,
  input  logic [ADDR_W-17:0] cpu_addr_hi,
  input  logic              cpu_sel,
  input  logic              cpu_mreq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic              cpu_rfsh_n,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait_n,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_wait,
  output logic              ld_overflow,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, CRD, CWR, LWR} state_t;

  state_t            state;
  logic              served;
  logic              creq, cpu_go, push, pop, fifo_full, fifo_empty;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic [ADDR_W-1:0] fifo_addr [LD_DEPTH];
  logic [7:0]        fifo_data [LD_DEPTH];

  // Refresh cycles never count as a request; rd_n and wr_n both low reads.
  assign creq       = cpu_sel & ~cpu_mreq_n & cpu_rfsh_n & (~cpu_rd_n | ~cpu_wr_n);
  assign cpu_wait_n = ~(creq & ~served);
  assign cpu_go     = (state == IDLE) & creq & ~served;
  assign fifo_full  = (count == CW'(LD_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = ld_wr & ~fifo_full;
  assign pop        = (state == IDLE) & ~cpu_go & ~fifo_empty;

  // Occupancy after this clk's push/pop; drives the registered ld_wait.
  always_comb begin
    count_nxt = count;
    if (push & ~pop)      count_nxt = count + 1'b1;
    else if (pop & ~push) count_nxt = count - 1'b1;
  end

  // Loader FIFO storage; contents need no reset since count gates use.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ld_addr;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  // Loader FIFO pointers, occupancy, back-pressure and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ld_wait     <= 1'b0;
      ld_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      ld_wait <= (count_nxt >= CW'(LD_DEPTH - 1));
      if (ld_wr & fifo_full) ld_overflow <= 1'b1;
    end
  end

  // Access FSM: one RAM access per Z80 memory cycle, loader fills the gaps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      served    <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      cpu_dout  <= 8'hFF;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_go & ~cpu_rd_n) begin
            mem_addr <= {cpu_addr_hi, cpu_addr};
            state    <= CRD;
          end else if (cpu_go) begin
            mem_addr  <= {cpu_addr_hi, cpu_addr};
            mem_wdata <= cpu_din;
            mem_we    <= 1'b1;
            served    <= 1'b1;
            state     <= CWR;
          end else if (pop) begin
            mem_addr  <= fifo_addr[rd_ptr];
            mem_wdata <= fifo_data[rd_ptr];
            mem_we    <= 1'b1;
            state     <= LWR;
          end
        end
        CRD: begin
          cpu_dout <= mem_rdata;
          served   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A dropped request re-arms the next bus cycle; overrides any set above.
      if (!creq) served <= 1'b0;
    end
  end
endmodule

// File: tb/tb_msx_ram_arbiter.sv
// Randomized bench for msx_ram_arbiter: Z80 bus cycles (reads, writes,
// refresh, deselected) mixed with loader bursts, checked cycle by cycle
// against a queue-based timing model plus a reference memory image.
module tb_msx_ram_arbiter;
  localparam int ADDR_W   = 18;
  localparam int LD_DEPTH = 4;
  localparam int MEM_N    = 1 << ADDR_W;

  logic              clk = 1'b0, reset = 1'b1;
  logic [15:0]       cpu_addr = '0;
  logic [1:0]        cpu_addr_hi = '0;
  logic              cpu_sel = 1'b0, cpu_mreq_n = 1'b1, cpu_rd_n = 1'b1;
  logic              cpu_wr_n = 1'b1, cpu_rfsh_n = 1'b1;
  logic [7:0]        cpu_din = '0, cpu_dout;
  logic              cpu_wait_n;
  logic              ld_wr = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [7:0]        ld_data = '0;
  logic              ld_wait, ld_overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata, mem_rdata;

  msx_ram_arbiter #(.ADDR_W(ADDR_W), .LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_addr_hi(cpu_addr_hi), .cpu_sel(cpu_sel),
    .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_rfsh_n(cpu_rfsh_n), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_wait_n(cpu_wait_n), .ld_wr(ld_wr), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_wait(ld_wait), .ld_overflow(ld_overflow),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM: address registered by the arbiter, data readable the following clk.
  logic [7:0] ram [0:MEM_N-1];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [ADDR_W-1:0] a; logic [7:0] d; } ent_t;
  ent_t              q[$];
  logic [7:0]        refm [0:MEM_N-1];
  int                m_busy;          // 0 free, 1 read in flight, 2 write clk
  bit                m_served, m_we, m_wait, m_ovf;
  logic [7:0]        m_dout, m_wdata;
  logic [ADDR_W-1:0] m_waddr, m_raddr;

  function automatic bit f_creq();
    return cpu_sel && !cpu_mreq_n && cpu_rfsh_n && (!cpu_rd_n || !cpu_wr_n);
  endfunction

  task automatic m_reset();
    q.delete();
    m_busy = 0; m_served = 0; m_we = 0; m_wait = 0; m_ovf = 0; m_dout = 8'hFF;
  endtask

  // Effect of the coming rising edge given the inputs currently driven.
  task automatic m_step();
    bit   creq, go, set_s, push_ok;
    ent_t e;
    creq = f_creq();
    if (m_we) refm[m_waddr] = m_wdata;   // write issued last clk lands now
    m_we = 0; set_s = 0;
    go = creq && !m_served;
    push_ok = ld_wr && (q.size() < LD_DEPTH);
    if (ld_wr && !push_ok) m_ovf = 1;
    if (m_busy == 1) begin
      m_dout = refm[m_raddr]; set_s = 1; m_busy = 0;
    end else if (m_busy == 2) begin
      m_busy = 0;
    end else if (go && !cpu_rd_n) begin
      m_raddr = {cpu_addr_hi, cpu_addr}; m_busy = 1;
    end else if (go) begin
      m_we = 1; m_waddr = {cpu_addr_hi, cpu_addr}; m_wdata = cpu_din;
      set_s = 1; m_busy = 2;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1; m_waddr = e.a; m_wdata = e.d; m_busy = 2;
    end
    if (push_ok) q.push_back({ld_addr, ld_data});
    m_served = creq && (m_served || set_s);
    m_wait = q.size() >= LD_DEPTH - 1;
  endtask

  task automatic bus_idle();
    cpu_mreq_n = 1; cpu_rd_n = 1; cpu_wr_n = 1; cpu_rfsh_n = 1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_dout", cpu_dout, 8'hFF);
    chk("rst_wait_n", cpu_wait_n, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ld_wait", ld_wait, 0);
    chk("rst_ovf", ld_overflow, 0);
  endtask

  initial begin
    int bus_left, gap_left, rate, r, mism;
    bit did_rst, quiet, saw_ovf;
    for (int i = 0; i < MEM_N; i++) begin
      ram[i]  = 8'(i * 7 + 3);
      refm[i] = 8'(i * 7 + 3);
    end
    m_reset();
    bus_left = 0; gap_left = 2; did_rst = 0; saw_ovf = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      quiet = cyc >= 3800;
      rate  = (cyc < 1000) ? 25 : (cyc < 2000) ? 85 : 40;
      // Z80 side: hold the cycle while WAIT is asserted, then a short gap.
      if (bus_left > 0 || (f_creq() && !m_served)) begin
        if (bus_left > 0) bus_left--;
      end else if (gap_left > 0 || quiet) begin
        bus_idle();
        if (gap_left > 0) gap_left--;
      end else begin
        r = $urandom_range(0, 15);
        cpu_sel     = (r != 0);
        cpu_mreq_n  = 0;
        cpu_rfsh_n  = (r == 1) ? 1'b0 : 1'b1;
        cpu_rd_n    = (r <= 8 || r == 15) ? 1'b0 : 1'b1;
        cpu_wr_n    = (r >= 9) ? 1'b0 : 1'b1;
        cpu_addr    = 16'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 16'h8000 : 16'h0000);
        cpu_addr_hi = 2'($urandom_range(0, 1));
        cpu_din     = 8'($urandom);
        bus_left    = $urandom_range(0, 5);
        gap_left    = $urandom_range(1, 3);
      end
      ld_wr   = !quiet && ($urandom_range(0, 99) < rate);
      ld_addr = 18'h20000 | 18'($urandom_range(0, 15));
      ld_data = 8'($urandom);
      #1;
      chk("wait_n", cpu_wait_n, !(f_creq() && !m_served));
      m_step();

      @(negedge clk);
      chk("mem_we", mem_we, m_we);
      if (m_we) begin
        chk("waddr", mem_addr, m_waddr);
        chk("wdata", mem_wdata, m_wdata);
      end
      if (m_busy == 1) chk("raddr", mem_addr, m_raddr);
      chk("dout", cpu_dout, m_dout);
      chk("ld_wait", ld_wait, m_wait);
      chk("ovf", ld_overflow, m_ovf);
      if (m_ovf) saw_ovf = 1;

      // Reset in the middle of a CPU read with loader bytes still queued.
      if (cyc >= 2500 && !did_rst && m_busy == 1 && q.size() >= 2) begin
        did_rst = 1;
        bus_idle(); ld_wr = 0;
        reset = 1;
        #1;
        chk_reset_vals();
        @(negedge clk);
        chk_reset_vals();
        reset = 0;
        m_reset();
        bus_left = 0; gap_left = 2;
      end
    end

    chk("reset_hit", did_rst, 1);
    chk("ovf_seen", saw_ovf, 1);
    mism = 0;
    for (int i = 0; i < MEM_N; i++) if (ram[i] !== refm[i]) mism++;
    chk("ram_image", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
